grid_scan_controller: RTL and testbench
=======================================

# grid_scan_controller

Frame-scan sequencer for the 16x12 snake playfield. On `start` it walks every cell in raster order, drives the cell coordinate to an internal `border_generator` and to the external snake/apple lookup logic, resolves the cell contents by fixed priority, and streams one classified cell per handshake to the display/frame-buffer side. It also flags a head collision (wall or self) found during the scan. It sits between game-state logic and the display writer.

## Interface
Parameters:
- `GRID_W`, default 16: columns; x range 0..15.
- `GRID_H`, default 12: rows; y range 0..11.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin a frame scan; sampled only in IDLE.
- `scan_x`  out  4  current query column to lookup logic.
- `scan_y`  out  4  current query row to lookup logic.
- `head_hit`  in  1  snake head occupies (`scan_x`,`scan_y`); combinational, same cycle.
- `body_hit`  in  1  snake body occupies the queried cell; same cycle.
- `apple_hit`  in  1  apple occupies the queried cell; same cycle.
- `out_valid`  out  1  output cell register holds a cell.
- `out_ready`  in  1  consumer accepts the cell this cycle.
- `out_x`, `out_y`  out  4 each  coordinate of the presented cell.
- `out_type`  out  3  `cell_t` of the presented cell.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse after the last cell is accepted.
- `collision`  out  1  sticky; head overlapped border or body during the current/last scan.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `busy`=0; `scan_x`/`scan_y`=0. `start`=1 -> SCAN, counters to (0,0), clear `collision`.
- SCAN: each cycle the query (`scan_x`,`scan_y`) is captured into the output register iff register empty or `out_valid && out_ready`. On capture: counter advances x+1; at x=GRID_W-1, x wraps to 0 and y+1. After capturing (15,11) counters stop; no further captures.
- Classification priority: BORDER (from `border_generator`: x=0, x=15, y=0 or y=11) > HEAD > BODY > APPLE > EMPTY.
- `collision` set on capture when `head_hit` && (isBorder || `body_hit`); holds until next accepted `start` or `rst`.
- When the (15,11) cell is accepted (`out_valid && out_ready`) -> DONE. DONE lasts one cycle, `done`=1, then IDLE.
- `start` in SCAN or DONE is ignored (no restart, no queueing).
- Coordinates outside grid never issued; counters are 4-bit, wrap compares against GRID_W-1/GRID_H-1, not 4-bit overflow.

## Timing
- Reset values: `scan_x`=0, `scan_y`=0, `out_valid`=0, `out_x`=0, `out_y`=0, `out_type`=EMPTY, `busy`=0, `done`=0, `collision`=0, state IDLE.
- `rst` mid-scan: next cycle all of the above; partial frame discarded, no `done`.
- `start` high at cycle N -> `busy`=1 from N+1; cell k (k=0..191) queried at N+1+k with no stalls; `out_valid` for cell k at N+2+k.
- Capture latency 1 cycle (query -> `out_*`). Throughput 1 cell/cycle with `out_ready`=1.
- With `out_ready` held 1: last cell presented N+193, `done`=1 and `busy`=0 at N+194, IDLE at N+195; `start` accepted again from N+195.
- Stall: `out_valid && !out_ready` -> `out_*` stable, counters hold, lookup inputs ignored that cycle.
- `out_valid` drops the cycle after acceptance if no new capture.

## Structure
- `snake_pkg`: `cell_t` enum (3 bits): EMPTY=0, BORDER=1, HEAD=2, BODY=3, APPLE=4; localparams GRID_W=16, GRID_H=12; shared with the display writer and game logic.
- One sub-module: `border_generator` instance (ports `x`, `y`, `isBorder`) fed by `scan_x`/`scan_y`. FSM, counters, priority mux and output register stay in this module.

## Test plan
- Reset: assert `rst` 2 cycles mid-operation -> all outputs at reset values next cycle, state IDLE.
- Full scan, `out_ready`=1, no hits: `start` at N -> 192 cells in raster order; (0,0),(15,5),(7,11) BORDER, (1,1),(14,10) EMPTY; `done` exactly at N+194, one cycle.
- Priority: `head_hit`=`body_hit`=`apple_hit`=1 at (5,5) -> HEAD; `apple_hit` at (0,3) -> BORDER; `body_hit`+`apple_hit` at (3,3) -> BODY.
- Backpressure: `out_ready`=0 for 5 cycles while (4,2) presented -> `out_*` unchanged, `scan_x`=5 held; release -> (5,2) next, no cell lost or duplicated.
- Collision: `head_hit` at (15,4) -> `collision`=1 from capture, stays through `done`; next `start` with no hits -> cleared.
- `start` pulsed during SCAN and DONE -> ignored; exactly one `done` per accepted `start`.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared playfield types: cell classification codes and grid geometry.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package snake_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;

  // Cell contents as seen by the display writer; encoding is shared with game logic.
  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    BORDER = 3'd1,
    HEAD   = 3'd2,
    BODY   = 3'd3,
    APPLE  = 3'd4
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Fixed priority resolution: border wins over anything the lookup reports,
  // then head, body, apple.
  function automatic cell_t classify_cell(input logic is_border,
                                          input logic head,
                                          input logic body,
                                          input logic apple);
    cell_t c;
    if (is_border)  c = BORDER;
    else if (head)  c = HEAD;
    else if (body)  c = BODY;
    else if (apple) c = APPLE;
    else            c = EMPTY;
    return c;
  endfunction

endpackage

// File: rtl/border_generator.sv
// Flags cells on the outer ring of the playfield.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the coordinate.
module border_generator #(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       isBorder
);

  localparam logic [3:0] LP_X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] LP_Y_LAST = 4'(GRID_H - 1);

  // Any coordinate on the first/last column or row is wall.
  always_comb begin
    isBorder = (x == 4'd0) || (x == LP_X_LAST) ||
               (y == 4'd0) || (y == LP_Y_LAST);
  end

endmodule

// File: rtl/grid_scan_controller.sv
// Raster-scans the playfield, classifies each cell and streams it out; flags head collisions.
// Latency: one cycle from query (scan_x/scan_y) to out_*; one cell per cycle when unstalled.
// Backpressure: out_valid && !out_ready freezes out_*, holds the counters and ignores lookup inputs.
module grid_scan_controller
  import snake_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] scan_x,
  output logic [3:0] scan_y,
  input  logic       head_hit,
  input  logic       body_hit,
  input  logic       apple_hit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_x,
  output logic [3:0] out_y,
  output logic [2:0] out_type,
  output logic       busy,
  output logic       done,
  output logic       collision
);

  localparam logic [3:0] LP_X_LAST = 4'(GRID_W - 1);
  localparam logic [3:0] LP_Y_LAST = 4'(GRID_H - 1);

  scan_state_t r_state;
  scan_state_t w_next_state;

  logic [3:0] r_x;
  logic [3:0] r_y;
  logic       r_last_cap;   // (last_x,last_y) already captured; no more queries issued

  logic       r_out_valid;
  logic [3:0] r_out_x;
  logic [3:0] r_out_y;
  cell_t      r_out_type;
  logic       r_collision;

  logic       w_is_border;
  logic       w_accept;
  logic       w_capture;
  logic       w_start_scan;
  logic       w_busy;
  logic       w_done;
  cell_t      w_cell_type;

  border_generator #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_border (
    .x        (r_x),
    .y        (r_y),
    .isBorder (w_is_border)
  );

  assign w_accept    = r_out_valid && out_ready;
  assign w_cell_type = classify_cell(w_is_border, head_hit, body_hit, apple_hit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and control strobes; capture only when the output slot is free or draining.
  always_comb begin
    w_next_state = r_state;
    w_start_scan = 1'b0;
    w_capture    = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_scan = 1'b1;
          w_next_state = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_busy    = 1'b1;
        w_capture = !r_last_cap && (!r_out_valid || out_ready);
        // Once the final cell is in the register, any acceptance is the final one.
        if (r_last_cap && w_accept) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Raster counters: advance on capture, wrap at the grid edge, park on the last cell.
  // Cleared on the way back to IDLE so the query outputs read (0,0) while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_last_cap <= 1'b0;
    end else if (w_start_scan || (r_state == ST_DONE)) begin
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_last_cap <= 1'b0;
    end else if (w_capture) begin
      if (r_x == LP_X_LAST) begin
        if (r_y == LP_Y_LAST) begin
          r_last_cap <= 1'b1;
        end else begin
          r_x <= 4'd0;
          r_y <= r_y + 4'd1;
        end
      end else begin
        r_x <= r_x + 4'd1;
      end
    end
  end

  // Output cell register: load on capture, empty after acceptance with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_x     <= 4'd0;
      r_out_y     <= 4'd0;
      r_out_type  <= EMPTY;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_x     <= r_x;
      r_out_y     <= r_y;
      r_out_type  <= w_cell_type;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky collision: head on a wall or on its own body; cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_collision <= 1'b0;
    end else if (w_start_scan) begin
      r_collision <= 1'b0;
    end else if (w_capture && head_hit && (w_is_border || body_hit)) begin
      r_collision <= 1'b1;
    end
  end

  assign scan_x    = r_x;
  assign scan_y    = r_y;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_type  = r_out_type;
  assign busy      = w_busy;
  assign done      = w_done;
  assign collision = r_collision;

endmodule

// File: tb/tb_grid_scan_controller.sv
// Directed bench for grid_scan_controller: reset, raster order, priority, stall, collision, start filtering.
// Latency: expectations are hand-timed relative to the start cycle N.
// Backpressure: exercised by deasserting out_ready around cell (4,2).
module tb_grid_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] scan_x, scan_y;
  logic       head_hit, body_hit, apple_hit;
  logic       out_valid, out_ready;
  logic [3:0] out_x, out_y;
  logic [2:0] out_type;
  logic       busy, done, collision;

  int errors = 0;
  int checks = 0;

  // Lookup model: cells encoded as {x,y}; 8'hFF is never queried so it means "unused".
  logic [7:0] head_cell;
  logic [7:0] body_cells [4];
  logic [7:0] apple_cells[4];

  always_comb begin
    head_hit  = (head_cell == {scan_x, scan_y});
    body_hit  = 1'b0;
    apple_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (body_cells[i]  == {scan_x, scan_y}) body_hit  = 1'b1;
      if (apple_cells[i] == {scan_x, scan_y}) apple_hit = 1'b1;
    end
  end

  grid_scan_controller #(.GRID_W(16), .GRID_H(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .scan_x    (scan_x),
    .scan_y    (scan_y),
    .head_hit  (head_hit),
    .body_hit  (body_hit),
    .apple_hit (apple_hit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_type  (out_type),
    .busy      (busy),
    .done      (done),
    .collision (collision)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hits;
    head_cell = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      body_cells[i]  = 8'hFF;
      apple_cells[i] = 8'hFF;
    end
  endtask

  // Frame capture, filled by run_frame and inspected by the scenario tasks.
  logic [3:0] rec_x[192];
  logic [3:0] rec_y[192];
  logic [2:0] rec_t[192];
  logic       rec_c[192];
  int         n_acc, done_cnt, done_off, first_vld_cyc;
  logic       busy1, busy_at_done, col_at_done, busy_end;

  // Pulses start at cycle N (cyc 0) and runs with out_ready=1 until 3 cycles after done.
  task automatic run_frame(input bit pulse_mid, input bit pulse_done);
    int cyc;
    bit timeout;
    n_acc = 0; done_cnt = 0; done_off = -1; first_vld_cyc = -1; timeout = 0;
    busy_at_done = 1'b0; col_at_done = 1'b0; busy_end = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    cyc = 1;
    busy1 = busy;
    while (1) begin
      start = 1'b0;
      if (pulse_mid && cyc == 50) start = 1'b1;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_valid && out_ready) begin
        if (n_acc < 192) begin
          rec_x[n_acc] = out_x;
          rec_y[n_acc] = out_y;
          rec_t[n_acc] = out_type;
          rec_c[n_acc] = collision;
        end
        n_acc++;
      end
      if (done) begin
        done_cnt++;
        if (done_off < 0) begin
          done_off     = cyc;
          busy_at_done = busy;
          col_at_done  = collision;
          if (pulse_done) start = 1'b1;
        end
      end
      if (done_off >= 0 && cyc >= done_off + 3) begin
        busy_end = busy;
        break;
      end
      if (cyc > 600) begin
        timeout = 1;
        break;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL frame_timeout: no done within %0d cycles, required done at 194", cyc);
    end
  endtask

  task automatic test_reset;
    clear_hits();
    head_cell = {4'd0, 4'd0};
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    checks++;
    if ({busy, out_valid, collision} !== 3'b111) begin
      errors++;
      $display("FAIL reset_precondition: busy/valid/collision=%b required 111", {busy, out_valid, collision});
    end
    rst = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b want 0", collision); end
    checks++; if ({scan_x, scan_y} !== 8'h00) begin errors++; $display("FAIL reset_scan: got %h want 00", {scan_x, scan_y}); end
    checks++; if ({out_x, out_y} !== 8'h00)   begin errors++; $display("FAIL reset_out_xy: got %h want 00", {out_x, out_y}); end
    checks++; if (out_type !== 3'd0)  begin errors++; $display("FAIL reset_out_type: got %0d want 0", out_type); end
    tick;
    rst = 1'b0;
    tick;
    tick;
    checks++;
    if ({busy, done, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_stays_idle: busy/done/valid=%b required 000", {busy, done, out_valid});
    end
    clear_hits();
  endtask

  task automatic test_full_scan;
    int bad_order, bad_type;
    logic [2:0] exp_t;
    clear_hits();
    run_frame(1'b0, 1'b0);
    bad_order = 0; bad_type = 0;
    for (int k = 0; k < 192; k++) begin
      if (rec_x[k] !== 4'(k % 16) || rec_y[k] !== 4'(k / 16)) bad_order++;
      exp_t = ((k % 16) == 0 || (k % 16) == 15 || (k / 16) == 0 || (k / 16) == 11) ? 3'd1 : 3'd0;
      if (rec_t[k] !== exp_t) bad_type++;
    end
    checks++; if (busy1 !== 1'b1)    begin errors++; $display("FAIL scan_busy_n1: got %b want 1", busy1); end
    checks++; if (first_vld_cyc != 2) begin errors++; $display("FAIL scan_first_valid: got N+%0d want N+2", first_vld_cyc); end
    checks++; if (n_acc != 192)      begin errors++; $display("FAIL scan_count: got %0d cells want 192", n_acc); end
    checks++; if (bad_order != 0)    begin errors++; $display("FAIL scan_order: %0d cells out of raster order, want 0", bad_order); end
    checks++; if (bad_type != 0)     begin errors++; $display("FAIL scan_types: %0d cells misclassified, want 0", bad_type); end
    checks++; if (rec_t[0] !== 3'd1)   begin errors++; $display("FAIL scan_0_0: got %0d want 1", rec_t[0]); end
    checks++; if (rec_t[95] !== 3'd1)  begin errors++; $display("FAIL scan_15_5: got %0d want 1", rec_t[95]); end
    checks++; if (rec_t[183] !== 3'd1) begin errors++; $display("FAIL scan_7_11: got %0d want 1", rec_t[183]); end
    checks++; if (rec_t[17] !== 3'd0)  begin errors++; $display("FAIL scan_1_1: got %0d want 0", rec_t[17]); end
    checks++; if (rec_t[174] !== 3'd0) begin errors++; $display("FAIL scan_14_10: got %0d want 0", rec_t[174]); end
    checks++; if (done_off != 194)   begin errors++; $display("FAIL scan_done_cycle: got N+%0d want N+194", done_off); end
    checks++; if (done_cnt != 1)     begin errors++; $display("FAIL scan_done_width: got %0d done cycles want 1", done_cnt); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL scan_busy_at_done: got %b want 0", busy_at_done); end
  endtask

  task automatic test_priority;
    clear_hits();
    head_cell      = {4'd5, 4'd5};
    body_cells[0]  = {4'd5, 4'd5};
    body_cells[1]  = {4'd3, 4'd3};
    apple_cells[0] = {4'd5, 4'd5};
    apple_cells[1] = {4'd3, 4'd3};
    apple_cells[2] = {4'd0, 4'd3};
    apple_cells[3] = {4'd9, 4'd7};
    run_frame(1'b0, 1'b0);
    checks++; if (rec_t[85] !== 3'd2)  begin errors++; $display("FAIL prio_head_5_5: got %0d want 2", rec_t[85]); end
    checks++; if (rec_t[48] !== 3'd1)  begin errors++; $display("FAIL prio_border_0_3: got %0d want 1", rec_t[48]); end
    checks++; if (rec_t[51] !== 3'd3)  begin errors++; $display("FAIL prio_body_3_3: got %0d want 3", rec_t[51]); end
    checks++; if (rec_t[121] !== 3'd4) begin errors++; $display("FAIL prio_apple_9_7: got %0d want 4", rec_t[121]); end
    clear_hits();
  endtask

  task automatic test_backpressure;
    int cyc, exp_k, bad_seq, end_cyc;
    clear_hits();
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1; exp_k = 0; bad_seq = 0; end_cyc = -1;
    while (cyc <= 600) begin
      out_ready = !(cyc >= 38 && cyc <= 42);
      if (cyc >= 38 && cyc <= 43) begin
        checks++;
        if ({out_valid, out_x, out_y, out_type, scan_x, scan_y} !== {1'b1, 4'd4, 4'd2, 3'd0, 4'd5, 4'd2}) begin
          errors++;
          $display("FAIL stall_hold_N+%0d: valid=%b out=(%0d,%0d) type=%0d scan=(%0d,%0d), want 1 (4,2) 0 (5,2)",
                   cyc, out_valid, out_x, out_y, out_type, scan_x, scan_y);
        end
      end
      if (cyc == 44) begin
        checks++;
        if ({out_valid, out_x, out_y} !== {1'b1, 4'd5, 4'd2}) begin
          errors++;
          $display("FAIL stall_release: valid=%b out=(%0d,%0d), want 1 (5,2)", out_valid, out_x, out_y);
        end
      end
      if (out_valid && out_ready) begin
        if (out_x !== 4'(exp_k % 16) || out_y !== 4'(exp_k / 16)) bad_seq++;
        exp_k++;
      end
      if (done) begin
        end_cyc = cyc;
        break;
      end
      tick;
      cyc++;
    end
    out_ready = 1'b1;
    checks++; if (end_cyc != 199) begin errors++; $display("FAIL stall_done_cycle: got N+%0d want N+199", end_cyc); end
    checks++; if (exp_k != 192)   begin errors++; $display("FAIL stall_count: got %0d cells want 192", exp_k); end
    checks++; if (bad_seq != 0)   begin errors++; $display("FAIL stall_sequence: %0d cells out of order want 0", bad_seq); end
    tick;
    tick;
  endtask

  task automatic test_collision;
    clear_hits();
    head_cell = {4'd15, 4'd4};
    run_frame(1'b0, 1'b0);
    checks++; if (rec_c[78] !== 1'b0)  begin errors++; $display("FAIL coll_before: got %b want 0", rec_c[78]); end
    checks++; if (rec_c[79] !== 1'b1)  begin errors++; $display("FAIL coll_at_capture: got %b want 1", rec_c[79]); end
    checks++; if (rec_t[79] !== 3'd1)  begin errors++; $display("FAIL coll_cell_type: got %0d want 1", rec_t[79]); end
    checks++; if (col_at_done !== 1'b1) begin errors++; $display("FAIL coll_through_done: got %b want 1", col_at_done); end
    checks++; if (collision !== 1'b1)  begin errors++; $display("FAIL coll_sticky_idle: got %b want 1", collision); end
    clear_hits();
    run_frame(1'b0, 1'b0);
    checks++; if (rec_c[0] !== 1'b0)   begin errors++; $display("FAIL coll_cleared: got %b want 0", rec_c[0]); end
    checks++; if (col_at_done !== 1'b0) begin errors++; $display("FAIL coll_clean_frame: got %b want 0", col_at_done); end
  endtask

  task automatic test_start_ignored;
    clear_hits();
    run_frame(1'b1, 1'b1);
    checks++; if (done_cnt != 1)     begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
    checks++; if (n_acc != 192)      begin errors++; $display("FAIL ign_cell_count: got %0d want 192", n_acc); end
    checks++; if (done_off != 194)   begin errors++; $display("FAIL ign_done_cycle: got N+%0d want N+194", done_off); end
    checks++; if (busy_end !== 1'b0) begin errors++; $display("FAIL ign_no_restart: busy=%b want 0", busy_end); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    clear_hits();
    tick;
    tick;
    rst = 1'b0;
    tick;
    test_reset();
    test_full_scan();
    test_priority();
    test_backpressure();
    test_collision();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
